axi_ram_tester: RTL

AXI_RAM_TESTER -- requirements
Module: axi_ram_tester

---
 rtl/axi_ram_tester_if.sv | 69 ++++++
 rtl/axi_ram_tester.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_tester_if.sv
// AXI4 bus bundle between the RAM tester (master) and the RAM model (slave).
interface axi_if #(
    parameter int unsigned ID_W_WIDTH = 4,
    parameter int unsigned ID_R_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [ID_W_WIDTH-1:0] awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_W_WIDTH-1:0] bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_R_WIDTH-1:0] arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_R_WIDTH-1:0] rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport m (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport s (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ram_tester.sv
// Write-then-read AXI4 burst tester: writes a seeded ramp, reads it back and reports pass/err_count.
// Define AXI_RAM_TESTER_ERR_CNT_EN for a saturating error counter; otherwise err_count is 0 and a sticky fail flag drives pass.
module axi_ram_tester #(
    parameter int unsigned           ID_W_WIDTH = 4,
    parameter int unsigned           ID_R_WIDTH = 4,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           BURST_LEN  = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    axi_if.m            axi_m
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
    localparam logic [2:0]  AXSIZE = 3'($clog2(STRB_W));
    localparam logic [7:0]  AXLEN  = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    state_t                state;
    logic                  start_q;
    logic                  awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [CNT_W-1:0]      wbeat, rbeat;

    logic                  accept, b_hs, r_hs, r_last_exp, r_end, clean;
    logic [DATA_WIDTH-1:0] r_exp;
    logic [2:0]            r_bad;
    logic [15:0]           missing, incr;

    assign axi_m.awid    = ID_W_WIDTH'(0);
    assign axi_m.awaddr  = BASE_ADDR;
    assign axi_m.awlen   = AXLEN;
    assign axi_m.awsize  = AXSIZE;
    assign axi_m.awburst = 2'b01;
    assign axi_m.awvalid = awvalid;
    assign axi_m.wdata   = wdata;
    assign axi_m.wstrb   = '1;
    assign axi_m.wlast   = wlast;
    assign axi_m.wvalid  = wvalid;
    assign axi_m.bready  = bready;
    assign axi_m.arid    = ID_R_WIDTH'(0);
    assign axi_m.araddr  = BASE_ADDR;
    assign axi_m.arlen   = AXLEN;
    assign axi_m.arsize  = AXSIZE;
    assign axi_m.arburst = 2'b01;
    assign axi_m.arvalid = arvalid;
    assign axi_m.rready  = rready;

    // Rising-edge start detect so a held start launches only one run
    assign accept     = (state == IDLE) && start && !start_q;
    assign b_hs       = bready && axi_m.bvalid;
    assign r_hs       = rready && axi_m.rvalid;
    assign r_last_exp = (32'(rbeat) + 32'd1 == BURST_LEN);
    assign r_end      = r_hs && (axi_m.rlast || r_last_exp);
    assign r_exp      = DATA_WIDTH'(SEED + 32'(rbeat));

    // Errors contributed by the handshake in this cycle; early RLAST also charges the unread beats
    always_comb begin
        r_bad   = 3'(axi_m.rdata != r_exp) + 3'(axi_m.rresp != 2'b00)
                + 3'(axi_m.rid != ID_R_WIDTH'(0)) + 3'(axi_m.rlast != r_last_exp);
        missing = 16'd0;
        if (axi_m.rlast && !r_last_exp)
            missing = 16'(BURST_LEN - 32'd1 - 32'(rbeat));
        incr = 16'd0;
        if (b_hs)
            incr = 16'(axi_m.bresp != 2'b00);
        else if (r_hs)
            incr = 16'(r_bad) + missing;
    end

`ifdef AXI_RAM_TESTER_ERR_CNT_EN
    logic [15:0] err_q, err_next;
    logic [16:0] err_sum;

    assign err_sum  = {1'b0, err_q} + {1'b0, incr};
    assign err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             err_q <= 16'd0;
        else if (accept)        err_q <= 16'd0;
        else if (incr != 16'd0) err_q <= err_next;
    end

    assign err_count = err_q;
    assign clean     = (err_next == 16'd0);
`else
    logic fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             fail <= 1'b0;
        else if (accept)        fail <= 1'b0;
        else if (incr != 16'd0) fail <= 1'b1;
    end

    assign err_count = 16'd0;
    assign clean     = !fail && (incr == 16'd0);
`endif

    // Control FSM; every VALID/READY is a register set on state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            wlast   <= 1'b0;
            wdata   <= '0;
            bready  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            wbeat   <= '0;
            rbeat   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state   <= AW;
                    awvalid <= 1'b1;
                    busy    <= 1'b1;
                    pass    <= 1'b0;
                    wbeat   <= '0;
                    rbeat   <= '0;
                    wdata   <= DATA_WIDTH'(SEED);
                end
                AW: if (axi_m.awready) begin
                    state   <= W;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    wlast   <= (BURST_LEN == 1);
                end
                W: if (axi_m.wready) begin
                    if (wlast) begin
                        state  <= B;
                        wvalid <= 1'b0;
                        wlast  <= 1'b0;
                        bready <= 1'b1;
                    end else begin
                        wbeat <= wbeat + CNT_W'(1);
                        wdata <= DATA_WIDTH'(SEED + 32'(wbeat) + 32'd1);
                        wlast <= (32'(wbeat) + 32'd2 == BURST_LEN);
                    end
                end
                B: if (axi_m.bvalid) begin
                    state   <= AR;
                    bready  <= 1'b0;
                    arvalid <= 1'b1;
                end
                AR: if (axi_m.arready) begin
                    state   <= R;
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                end
                R: if (r_hs) begin
                    rbeat <= rbeat + CNT_W'(1);
                    if (r_end) begin
                        state  <= DONE;
                        rready <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= clean;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
